// File: rtl/sm_muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and small op-class helpers.
package sm_muldiv_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [2:0] {
        MDS_IDLE = 3'd0,
        MDS_PREP = 3'd1,
        MDS_RUN  = 3'd2,
        MDS_FIX  = 3'd3,
        MDS_DONE = 3'd4
    } mdState_t;

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return !((op == MD_MULTU) || (op == MD_DIVU));
    endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One iteration of the bit-serial datapath: LSB-first shift-add for multiply,
// restoring shift-subtract for divide. acc holds {upper half, lower half}.
module sm_muldiv_step
    import sm_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   accNext
);

    logic [WIDTH:0] mulSum;
    logic [WIDTH:0] divTrial;

    // Next accumulator: multiplier bits leave at the bottom while the partial
    // product enters at the top; for divide, dividend bits shift into the
    // remainder and quotient bits fill in from the bottom.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        divTrial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        accNext  = {mulSum, acc[WIDTH-1:1]};
        if (isDiv) begin
            if (divTrial[WIDTH]) begin
                accNext = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                accNext = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/sm_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair. Operands
// are reduced to magnitudes, iterated one bit per clock, then sign-fixed and
// written back. MTHI/MTLO writes are accepted whenever not busy.
module sm_muldiv_ctrl
    import sm_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             abort,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    mdState_t             state;
    logic [CNT_W-1:0]     counter;
    logic [1:0]           opR;
    logic [WIDTH-1:0]     aR;
    logic [WIDTH-1:0]     bR;
    logic [WIDTH-1:0]     operand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   accNext;
    logic                 resultNeg;
    logic                 remNeg;
    logic                 signA;
    logic                 signB;
    logic [2*WIDTH-1:0]   prodFix;
    logic [WIDTH-1:0]     quotFix;
    logic [WIDTH-1:0]     remFix;

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negP(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    sm_muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv   (isDivOp(opR)),
        .acc     (acc),
        .operand (operand),
        .accNext (accNext)
    );

    assign signA = isSignedOp(opR) & aR[WIDTH-1];
    assign signB = isSignedOp(opR) & bR[WIDTH-1];
    assign stall = busy | (start & (state == MDS_IDLE));

    // Sign fix-up of the finished iteration, consumed on the FIX->DONE edge.
    always_comb begin
        prodFix = negP(acc, resultNeg);
        quotFix = negW(acc[WIDTH-1:0], resultNeg);
        remFix  = negW(acc[2*WIDTH-1:WIDTH], remNeg);
    end

    // Sequencer FSM, iteration counter, status flags and the HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MDS_IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MDS_IDLE: begin
                    if (hiWe) hi <= wdata;
                    if (loWe) lo <= wdata;
                    if (start && !abort) begin
                        state <= MDS_PREP;
                        busy  <= 1'b1;
                    end
                end
                MDS_PREP: begin
                    if (abort) begin
                        state <= MDS_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= MDS_RUN;
                        counter <= CNT_W'(WIDTH - 1);
                    end
                end
                MDS_RUN: begin
                    if (abort) begin
                        state <= MDS_IDLE;
                        busy  <= 1'b0;
                    end else if (counter == '0) begin
                        state <= MDS_FIX;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                MDS_FIX: begin
                    if (abort) begin
                        state <= MDS_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= MDS_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (isDivOp(opR)) begin
                            hi <= remFix;
                            lo <= quotFix;
                        end else begin
                            hi <= prodFix[2*WIDTH-1:WIDTH];
                            lo <= prodFix[WIDTH-1:0];
                        end
                    end
                end
                MDS_DONE: begin
                    if (hiWe) hi <= wdata;
                    if (loWe) lo <= wdata;
                    state <= MDS_IDLE;
                end
                default: begin
                    state <= MDS_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture, magnitude/sign preparation and per-cycle iteration.
    // A divide by zero keeps the quotient all-ones by suppressing its negate.
    always_ff @(posedge clk) begin
        case (state)
            MDS_IDLE: begin
                if (start) begin
                    opR <= op;
                    aR  <= srcA;
                    bR  <= srcB;
                end
            end
            MDS_PREP: begin
                if (isDivOp(opR)) begin
                    acc       <= {{WIDTH{1'b0}}, absVal(aR, signA)};
                    operand   <= absVal(bR, signB);
                    resultNeg <= (signA ^ signB) && (bR != '0);
                    remNeg    <= signA;
                end else begin
                    acc       <= {{WIDTH{1'b0}}, absVal(bR, signB)};
                    operand   <= absVal(aR, signA);
                    resultNeg <= signA ^ signB;
                    remNeg    <= 1'b0;
                end
            end
            MDS_RUN: begin
                acc <= accNext;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sm_muldiv_ctrl.sv
// Bench for the multiply/divide sequencer: directed corner cases plus random
// operations, compared with an arithmetic reference of MIPS HI/LO semantics.
module tb_sm_muldiv_ctrl;
    import sm_muldiv_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        abort;
    logic        hiWe;
    logic        loWe;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mHi = 32'h0;
    logic [31:0] mLo = 32'h0;

    sm_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .abort (abort),
        .hiWe  (hiWe),
        .loWe  (loWe),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // HI/LO result of one operation, from plain integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = 32'h0;
        el = 32'h0;
        case (o)
            MD_MULT: begin
                p = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            MD_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (o == MD_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // Issue one op in the current (idle) cycle and follow it to done.
    // Busy-time MTHI/MTLO and a second start are thrown in and must be ignored.
    task automatic doOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit mtlo, input bit mthiDone);
        logic [31:0] eh, el;
        int doneAt;
        int stallCnt;
        model(o, a, b, eh, el);
        op = o; srcA = a; srcB = b; start = 1'b1;
        if (mtlo) begin
            loWe = 1'b1; wdata = 32'h1234; mLo = 32'h1234;
        end
        #1;
        stallCnt = stall ? 1 : 0;
        doneAt = -1;
        for (int c = 1; c <= 40 && doneAt < 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
            srcA = $urandom; srcB = $urandom; op = 2'($urandom);
            if (c == 10) begin
                hiWe = 1'b1; loWe = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (c == 12) start = 1'b1;
            #1;
            if (c == 1 && mtlo) check({tag, "_mtlo"}, 64'(lo), 64'h1234);
            if (c == 20) begin
                check({tag, "_hi_hold"}, 64'(hi), 64'(mHi));
                check({tag, "_lo_hold"}, 64'(lo), 64'(mLo));
            end
            if (done) doneAt = c;
            else if (stall) stallCnt++;
        end
        check({tag, "_latency"}, 64'(doneAt), 64'd35);
        check({tag, "_stall_cycles"}, 64'(stallCnt), 64'd35);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        mHi = eh;
        mLo = el;
        if (mthiDone) begin
            hiWe = 1'b1; wdata = 32'h0BAD_F00D;
            @(posedge clk); #1;
            hiWe = 1'b0;
            mHi = 32'h0BAD_F00D;
            check({tag, "_mthi_done_hi"}, 64'(hi), 64'(mHi));
            check({tag, "_mthi_done_lo"}, 64'(lo), 64'(mLo));
        end else begin
            @(posedge clk); #1;
        end
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] edges [5];
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        bit          sawDone;

        edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000; edges[4] = 32'h7FFF_FFFF;

        rst = 1'b1; start = 1'b0; op = MD_MULT; srcA = '0; srcB = '0;
        abort = 1'b0; hiWe = 1'b0; loWe = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        doOp(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0, 1'b0);
        check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0001);
        doOp(MD_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b0, 1'b0);
        check("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);
        doOp(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0, 1'b0);
        check("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
        doOp(MD_DIVU, 32'd100, 32'd0, "divu_zero", 1'b0, 1'b0);
        doOp(MD_DIV, 32'hFFFF_FF9C, 32'd0, "div_zero_neg", 1'b0, 1'b0);
        doOp(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, 1'b0);
        check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        doOp(MD_MULTU, 32'd5, 32'd6, "mtlo_start", 1'b1, 1'b0);
        doOp(MD_DIVU, 32'd1000, 32'd7, "mthi_in_done", 1'b0, 1'b1);

        // Abort part-way through RUN.
        op = MD_MULTU; srcA = 32'd2; srcB = 32'd3; start = 1'b1;
        sawDone = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = (c == 10);
            #1;
            if (c == 11) begin
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_stall", 64'(stall), 64'd0);
            end
            if (done) sawDone = 1'b1;
        end
        check("abort_no_done", 64'(sawDone), 64'd0);
        check("abort_hi", 64'(hi), 64'(mHi));
        check("abort_lo", 64'(lo), 64'(mLo));

        // Abort together with start in IDLE: nothing begins.
        start = 1'b1; abort = 1'b1; op = MD_DIVU; srcA = 32'd9; srcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        #1;
        check("abort_start_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("abort_start_busy2", 64'(busy), 64'd0);
        check("abort_start_done", 64'(done), 64'd0);

        // Reset in the middle of a DIVU.
        op = MD_DIVU; srcA = 32'd12345; srcB = 32'd17; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        mHi = 32'h0;
        mLo = 32'h0;
        doOp(MD_DIVU, 32'd12345, 32'd17, "after_rst", 1'b0, 1'b0);

        // Random operations, with occasional boundary operands.
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            doOp(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
